id_alu_decode: RTL and testbench
================================

# id_alu_decode

Decode-stage block that turns a fetched RV32I instruction plus register-file read data into an ALU operation (op code from `defines.vh` `ALU_OP_*`), two ALU operands, and write-back/memory/branch controls. It registers these into a single-entry ID/EX pipeline register with a valid/ready handshake. It sits between fetch/register-file read and the execute-stage ALU, and is the producer of the ALU's `A`/`B`/`op` interface.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `in_valid`  in  1  instruction/pc/rs data valid
- `in_ready`  out  1  block can accept this cycle
- `inst`  in  32  instruction word
- `pc`  in  32  instruction address
- `rs1_data`, `rs2_data`  in  32 each  register-file read data for inst[19:15], inst[24:20]
- `flush`  in  1  kill held and incoming instruction
- `out_ready`  in  1  execute stage accepts
- `out_valid`  out  1  ID/EX register holds an instruction
- `alu_a`, `alu_b`  out  32 each  ALU operands
- `alu_op`  out  4  ALU op code (`ALU_OP_*`)
- `imm`  out  32  sign-extended immediate
- `pc_out`  out  32  pc of held instruction
- `rd`  out  5  destination register
- `rf_we`, `mem_re`, `mem_we`, `is_branch`, `is_jump`  out  1 each  controls
- `illegal`  out  1  unsupported encoding flag

## Operation
- Decode is combinational from `inst`; results are captured on accept (`in_valid && in_ready && !flush`).
- R-type (0x33): add/sub/and/or/xor/sll/srl/sra → `ALU_OP_ADD/SUB/AND/OR/XOR/SLL/SLR/SAR`; a=rs1, b=rs2, rf_we=1.
- I-ALU (0x13): addi→`ALU_OP_ADDI`; andi/ori/xori→AND/OR/XOR; slli/srli/srai→SLL/SLR/SAR with b={27'b0,shamt}; a=rs1, b=imm, rf_we=1.
- LUI (0x37): a=0, b={inst[31:12],12'b0}, ADD, rf_we=1.
- Load lw (0x03, f3=2): ADD rs1+imm, mem_re=1, rf_we=1. Store sw (0x23, f3=2): ADD rs1+S-imm, mem_we=1, rf_we=0.
- Branch (0x63) beq/bne/blt/bge: a=rs1, b=rs2, `alu_op` = the matching `ALU_OP_SUBOP` family member so the ALU's `f` gives branch-taken; is_branch=1, imm=B-imm, rf_we=0.
- JAL (0x6F)/JALR (0x67, f3=0): a=pc, b=32'd4, ADD, rf_we=1, is_jump=1, imm=J-/I-imm.
- rd=0 forces rf_we=0 (operands unchanged).
- Unsupported encoding: see Configuration; always rf_we=mem_re=mem_we=is_branch=is_jump=0, alu_op=ADD, a=b=0.
- Immediates sign-extended from inst[31] to 32 bits.

## Timing
- Latency: 1 cycle; instruction accepted at edge N appears on outputs after edge N.
- `in_ready = !out_valid || out_ready`; combinational, no dependence on `in_valid`.
- Held outputs stable while `out_valid && !out_ready`.
- Simultaneous transfer-out and accept: register reloads, out_valid stays 1 (full throughput, no bubble).
- `flush`: out_valid=0 next edge, incoming instruction dropped regardless of handshake; flush wins over accept.
- Reset (`rst_n`=0 at edge, including mid-stall): out_valid=0, all data/control outputs 0, alu_op=`ALU_OP_ADD`, illegal=0.
- When out_valid=0, all control outputs (rf_we, mem_*, is_*, illegal) read 0.

## Configuration
- `ID_ILLEGAL_CHECK_EN` defined: any opcode/funct3/funct7 outside the supported set sets `illegal`=1 on the held instruction with side-effect controls 0.
- Undefined: `illegal` tied 0; unsupported encodings decode silently as a NOP (ADD, 0+0, all controls 0). Supported-instruction behaviour identical in both builds.

## Test plan
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 → next cycle alu_op=ADD, a=5, b=7, rd=3, rf_we=1; sub (0x402081B3) → alu_op=SUB.
- addi x5,x0,-1 (0xFFF00293) → alu_op=ADDI, imm=b=0xFFFFFFFF, rd=5; srai x6,x1,3 (0x4030D313) → SAR, b=3.
- beq x1,x2,+8 (0x00208463) → is_branch=1, imm=8, rf_we=0, a/b=rs1/rs2; lui x7,0x12345 (0x123453B7) → a=0, b=0x12345000.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, outputs frozen; release → back-to-back accepts, no bubble.
- flush asserted with in_valid=1 and held instruction → out_valid=0 next edge, neither instruction delivered; rst_n=0 mid-stall → all outputs 0.
- inst 0xFFFFFFFF with `ID_ILLEGAL_CHECK_EN` → illegal=1, rf_we=0; without → illegal=0, NOP controls.

Source files
------------

// File: rtl/id_alu_decode_if.sv
// ---------------------------------------------------------------------------
// id_alu_decode_if
//   Handshake and data bundle between fetch/register-file read, the decode
//   stage and the execute-stage ALU.
//
//   Upstream side : inValid, inReady, inst, pc, rs1Data, rs2Data, flush
//   Downstream    : outReady, outValid, aluA, aluB, aluOp, imm, pcOut, rd,
//                   rfWe, memRe, memWe, isBranch, isJump, illegal
//
//   Modports
//     slave  : the decode block itself
//     master : the environment around it (fetch + execute, or a bench)
// ---------------------------------------------------------------------------
interface id_alu_decode_if;
  logic        inValid;
  logic        inReady;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        flush;
  logic        outReady;
  logic        outValid;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic [3:0]  aluOp;
  logic [31:0] imm;
  logic [31:0] pcOut;
  logic [4:0]  rd;
  logic        rfWe;
  logic        memRe;
  logic        memWe;
  logic        isBranch;
  logic        isJump;
  logic        illegal;

  modport slave (
    input  inValid, inst, pc, rs1Data, rs2Data, flush, outReady,
    output inReady, outValid, aluA, aluB, aluOp, imm, pcOut, rd,
           rfWe, memRe, memWe, isBranch, isJump, illegal
  );

  modport master (
    output inValid, inst, pc, rs1Data, rs2Data, flush, outReady,
    input  inReady, outValid, aluA, aluB, aluOp, imm, pcOut, rd,
           rfWe, memRe, memWe, isBranch, isJump, illegal
  );
endinterface

// File: rtl/id_alu_decode.sv
// ---------------------------------------------------------------------------
// id_alu_decode
//   RV32I decode stage: turns an instruction plus register-file read data
//   into ALU op/operands and write-back/memory/branch controls, held in a
//   single-entry ID/EX register with a valid/ready handshake.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : synchronous active-low reset
//     bus    : id_alu_decode_if.slave (handshake, instruction, decoded fields)
//
//   Optional feature macro: ID_ILLEGAL_CHECK_EN
//     defined   -> unsupported encodings raise 'illegal' on the held entry
//     undefined -> 'illegal' is tied low; unsupported encodings become a NOP
//
//   ALU op encodings (shared with the execute-stage ALU):
//     0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SLR, 7 SAR, 8 ADDI,
//     9 SUBEQ, 10 SUBNE, 11 SUBLT, 12 SUBGE  (SUB* = branch compare family)
// ---------------------------------------------------------------------------
module id_alu_decode (
  input logic            clk,
  input logic            rst_n,
  id_alu_decode_if.slave bus
);

  localparam logic [3:0] ALU_OP_ADD   = 4'd0;
  localparam logic [3:0] ALU_OP_SUB   = 4'd1;
  localparam logic [3:0] ALU_OP_AND   = 4'd2;
  localparam logic [3:0] ALU_OP_OR    = 4'd3;
  localparam logic [3:0] ALU_OP_XOR   = 4'd4;
  localparam logic [3:0] ALU_OP_SLL   = 4'd5;
  localparam logic [3:0] ALU_OP_SLR   = 4'd6;
  localparam logic [3:0] ALU_OP_SAR   = 4'd7;
  localparam logic [3:0] ALU_OP_ADDI  = 4'd8;
  localparam logic [3:0] ALU_OP_SUBEQ = 4'd9;
  localparam logic [3:0] ALU_OP_SUBNE = 4'd10;
  localparam logic [3:0] ALU_OP_SUBLT = 4'd11;
  localparam logic [3:0] ALU_OP_SUBGE = 4'd12;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd;
  logic [31:0] w_immI;
  logic [31:0] w_immS;
  logic [31:0] w_immB;
  logic [31:0] w_immU;
  logic [31:0] w_immJ;
  logic [31:0] w_shamt;

  logic        w_legal;
  logic        w_illegal;
  logic [3:0]  w_aluOp;
  logic [31:0] w_aluA;
  logic [31:0] w_aluB;
  logic [31:0] w_imm;
  logic        w_rfWe;
  logic        w_memRe;
  logic        w_memWe;
  logic        w_isBranch;
  logic        w_isJump;

  logic        w_inReady;
  logic        w_accept;

  logic        r_valid;
  logic [3:0]  r_aluOp;
  logic [31:0] r_aluA;
  logic [31:0] r_aluB;
  logic [31:0] r_imm;
  logic [31:0] r_pc;
  logic [4:0]  r_rd;
  logic        r_rfWe;
  logic        r_memRe;
  logic        r_memWe;
  logic        r_isBranch;
  logic        r_isJump;
  logic        r_illegal;

  assign w_opcode = bus.inst[6:0];
  assign w_funct3 = bus.inst[14:12];
  assign w_funct7 = bus.inst[31:25];
  assign w_rd     = bus.inst[11:7];

  assign w_immI  = {{20{bus.inst[31]}}, bus.inst[31:20]};
  assign w_immS  = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
  assign w_immB  = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                    bus.inst[30:25], bus.inst[11:8], 1'b0};
  assign w_immU  = {bus.inst[31:12], 12'b0};
  assign w_immJ  = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                    bus.inst[20], bus.inst[30:21], 1'b0};
  assign w_shamt = {27'b0, bus.inst[24:20]};

  // Combinational decode. Each supported opcode fills in its fields and
  // marks itself legal; anything left unmarked is collapsed to a NOP at the
  // end, so unsupported encodings can never leak side-effect controls.
  always_comb begin
    w_legal    = 1'b0;
    w_aluOp    = ALU_OP_ADD;
    w_aluA     = 32'd0;
    w_aluB     = 32'd0;
    w_imm      = 32'd0;
    w_rfWe     = 1'b0;
    w_memRe    = 1'b0;
    w_memWe    = 1'b0;
    w_isBranch = 1'b0;
    w_isJump   = 1'b0;

    case (w_opcode)
      7'h33: begin
        w_aluA  = bus.rs1Data;
        w_aluB  = bus.rs2Data;
        w_rfWe  = 1'b1;
        w_legal = 1'b1;
        case ({w_funct7, w_funct3})
          10'b0000000_000: w_aluOp = ALU_OP_ADD;
          10'b0100000_000: w_aluOp = ALU_OP_SUB;
          10'b0000000_111: w_aluOp = ALU_OP_AND;
          10'b0000000_110: w_aluOp = ALU_OP_OR;
          10'b0000000_100: w_aluOp = ALU_OP_XOR;
          10'b0000000_001: w_aluOp = ALU_OP_SLL;
          10'b0000000_101: w_aluOp = ALU_OP_SLR;
          10'b0100000_101: w_aluOp = ALU_OP_SAR;
          default:         w_legal = 1'b0;
        endcase
      end
      7'h13: begin
        w_aluA  = bus.rs1Data;
        w_aluB  = w_immI;
        w_imm   = w_immI;
        w_rfWe  = 1'b1;
        w_legal = 1'b1;
        case (w_funct3)
          3'd0: w_aluOp = ALU_OP_ADDI;
          3'd4: w_aluOp = ALU_OP_XOR;
          3'd6: w_aluOp = ALU_OP_OR;
          3'd7: w_aluOp = ALU_OP_AND;
          3'd1: begin
            // Shift-immediates take only the 5-bit shamt as operand B.
            w_aluOp = ALU_OP_SLL;
            w_aluB  = w_shamt;
            w_legal = (w_funct7 == 7'h00);
          end
          3'd5: begin
            w_aluB  = w_shamt;
            w_aluOp = (w_funct7 == 7'h20) ? ALU_OP_SAR : ALU_OP_SLR;
            w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
          end
          default: w_legal = 1'b0;
        endcase
      end
      7'h37: begin
        w_aluB  = w_immU;
        w_imm   = w_immU;
        w_rfWe  = 1'b1;
        w_legal = 1'b1;
      end
      7'h03: begin
        w_aluA  = bus.rs1Data;
        w_aluB  = w_immI;
        w_imm   = w_immI;
        w_rfWe  = 1'b1;
        w_memRe = 1'b1;
        w_legal = (w_funct3 == 3'd2);
      end
      7'h23: begin
        w_aluA  = bus.rs1Data;
        w_aluB  = w_immS;
        w_imm   = w_immS;
        w_memWe = 1'b1;
        w_legal = (w_funct3 == 3'd2);
      end
      7'h63: begin
        w_aluA     = bus.rs1Data;
        w_aluB     = bus.rs2Data;
        w_imm      = w_immB;
        w_isBranch = 1'b1;
        w_legal    = 1'b1;
        case (w_funct3)
          3'd0:    w_aluOp = ALU_OP_SUBEQ;
          3'd1:    w_aluOp = ALU_OP_SUBNE;
          3'd4:    w_aluOp = ALU_OP_SUBLT;
          3'd5:    w_aluOp = ALU_OP_SUBGE;
          default: w_legal = 1'b0;
        endcase
      end
      7'h6F: begin
        // Jumps compute the link address pc+4 in the ALU.
        w_aluA   = bus.pc;
        w_aluB   = 32'd4;
        w_imm    = w_immJ;
        w_rfWe   = 1'b1;
        w_isJump = 1'b1;
        w_legal  = 1'b1;
      end
      7'h67: begin
        w_aluA   = bus.pc;
        w_aluB   = 32'd4;
        w_imm    = w_immI;
        w_rfWe   = 1'b1;
        w_isJump = 1'b1;
        w_legal  = (w_funct3 == 3'd0);
      end
      default: w_legal = 1'b0;
    endcase

    if (!w_legal) begin
      w_aluOp    = ALU_OP_ADD;
      w_aluA     = 32'd0;
      w_aluB     = 32'd0;
      w_imm      = 32'd0;
      w_rfWe     = 1'b0;
      w_memRe    = 1'b0;
      w_memWe    = 1'b0;
      w_isBranch = 1'b0;
      w_isJump   = 1'b0;
    end

    // Writes to x0 are discarded; operands are left as decoded.
    if (w_rd == 5'd0) begin
      w_rfWe = 1'b0;
    end
  end

`ifdef ID_ILLEGAL_CHECK_EN
  assign w_illegal = !w_legal;
`else
  assign w_illegal = 1'b0;
`endif

  // Ready depends only on occupancy and downstream ready, so a held entry
  // leaving and a new one arriving can share the same edge.
  assign w_inReady = !r_valid || bus.outReady;
  assign w_accept  = bus.inValid && w_inReady;

  // ID/EX register. Flush beats accept; data is only rewritten on accept,
  // which keeps held outputs frozen while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_aluOp    <= ALU_OP_ADD;
      r_aluA     <= 32'd0;
      r_aluB     <= 32'd0;
      r_imm      <= 32'd0;
      r_pc       <= 32'd0;
      r_rd       <= 5'd0;
      r_rfWe     <= 1'b0;
      r_memRe    <= 1'b0;
      r_memWe    <= 1'b0;
      r_isBranch <= 1'b0;
      r_isJump   <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_aluOp    <= w_aluOp;
      r_aluA     <= w_aluA;
      r_aluB     <= w_aluB;
      r_imm      <= w_imm;
      r_pc       <= bus.pc;
      r_rd       <= w_rd;
      r_rfWe     <= w_rfWe;
      r_memRe    <= w_memRe;
      r_memWe    <= w_memWe;
      r_isBranch <= w_isBranch;
      r_isJump   <= w_isJump;
      r_illegal  <= w_illegal;
    end else if (bus.outReady) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.inReady  = w_inReady;
  assign bus.outValid = r_valid;
  assign bus.aluOp    = r_aluOp;
  assign bus.aluA     = r_aluA;
  assign bus.aluB     = r_aluB;
  assign bus.imm      = r_imm;
  assign bus.pcOut    = r_pc;
  assign bus.rd       = r_rd;

  // Controls are masked by valid so an emptied register never shows stale
  // side effects.
  assign bus.rfWe     = r_rfWe     && r_valid;
  assign bus.memRe    = r_memRe    && r_valid;
  assign bus.memWe    = r_memWe    && r_valid;
  assign bus.isBranch = r_isBranch && r_valid;
  assign bus.isJump   = r_isJump   && r_valid;
  assign bus.illegal  = r_illegal  && r_valid;

endmodule

// File: tb/tb_id_alu_decode.sv
// ---------------------------------------------------------------------------
// tb_id_alu_decode
//   Table of instruction vectors with expected decode, driven through the
//   handshake; expected records are queued on accept and compared when the
//   ID/EX register hands them off. Hand-written sequences cover stall,
//   flush and reset-during-stall.
// ---------------------------------------------------------------------------
module tb_id_alu_decode;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SAR   = 4'd7;
  localparam logic [3:0] OP_ADDI  = 4'd8;
  localparam logic [3:0] OP_SUBEQ = 4'd9;
  localparam logic [3:0] OP_SUBNE = 4'd10;

`ifdef ID_ILLEGAL_CHECK_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  localparam int NV = 13;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  aluOp;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [5:0]  ctl;
  } vec_t;

  logic clk;
  logic rst_n;
  id_alu_decode_if bus ();

  id_alu_decode dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  vec_t vecs [NV];
  vec_t curVec;
  vec_t sb [$];
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [5:0] ctl);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.aluOp = op;
    v.a = a; v.b = b; v.imm = imm; v.rd = rd; v.ctl = ctl;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic v,
                               input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    curVec       = vecs[idx];
    bus.inst     = vecs[idx].inst;
    bus.pc       = vecs[idx].pc;
    bus.rs1Data  = vecs[idx].rs1;
    bus.rs2Data  = vecs[idx].rs2;
    bus.inValid  = v;
    bus.outReady = ordy;
    bus.flush    = fl;
  endtask

  // Scoreboard: compare the held entry as it leaves, then queue whatever is
  // being accepted on the same edge. Flush and reset drop everything queued.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.outValid && bus.outReady) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedOut got=pc %h exp=no output at %0t",
                   bus.pcOut, $time);
        end else begin
          vec_t e;
          e = sb.pop_front();
          checkOutput("aluOp",    32'(bus.aluOp),    32'(e.aluOp));
          checkOutput("aluA",     bus.aluA,          e.a);
          checkOutput("aluB",     bus.aluB,          e.b);
          checkOutput("imm",      bus.imm,           e.imm);
          checkOutput("pcOut",    bus.pcOut,         e.pc);
          checkOutput("rd",       32'(bus.rd),       32'(e.rd));
          checkOutput("rfWe",     32'(bus.rfWe),     32'(e.ctl[5]));
          checkOutput("memRe",    32'(bus.memRe),    32'(e.ctl[4]));
          checkOutput("memWe",    32'(bus.memWe),    32'(e.ctl[3]));
          checkOutput("isBranch", 32'(bus.isBranch), 32'(e.ctl[2]));
          checkOutput("isJump",   32'(bus.isJump),   32'(e.ctl[1]));
          checkOutput("illegal",  32'(bus.illegal),  32'(e.ctl[0]));
        end
      end
      if (bus.flush) begin
        sb.delete();
      end else if (bus.inValid && bus.inReady) begin
        sb.push_back(curVec);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    bus.flush    = 1'b0;
    bus.inst     = 32'd0;
    bus.pc       = 32'd0;
    bus.rs1Data  = 32'd0;
    bus.rs2Data  = 32'd0;

    //              inst          pc       rs1           rs2      op        a             b             imm           rd     {rfWe,memRe,memWe,br,jmp,ill}
    vecs[0]  = mk(32'h002081B3, 32'h100, 32'd5,        32'd7,   OP_ADD,   32'd5,        32'd7,        32'd0,        5'd3,  6'b100000);
    vecs[1]  = mk(32'h402081B3, 32'h104, 32'd5,        32'd7,   OP_SUB,   32'd5,        32'd7,        32'd0,        5'd3,  6'b100000);
    vecs[2]  = mk(32'hFFF00293, 32'h108, 32'd0,        32'd9,   OP_ADDI,  32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  6'b100000);
    vecs[3]  = mk(32'h4030D313, 32'h10C, 32'h80000000, 32'd1,   OP_SAR,   32'h80000000, 32'd3,        32'h00000403, 5'd6,  6'b100000);
    vecs[4]  = mk(32'h00208463, 32'h110, 32'h11,       32'h22,  OP_SUBEQ, 32'h11,       32'h22,       32'd8,        5'd8,  6'b000100);
    vecs[5]  = mk(32'h123453B7, 32'h114, 32'hDEAD,     32'hBEEF, OP_ADD,  32'd0,        32'h12345000, 32'h12345000, 5'd7,  6'b100000);
    vecs[6]  = mk(32'h0100A203, 32'h118, 32'h1000,     32'd0,   OP_ADD,   32'h1000,     32'd16,       32'd16,       5'd4,  6'b110000);
    vecs[7]  = mk(32'hFE20AE23, 32'h11C, 32'h2000,     32'h55,  OP_ADD,   32'h2000,     32'hFFFFFFFC, 32'hFFFFFFFC, 5'h1C, 6'b001000);
    vecs[8]  = mk(32'h010000EF, 32'h200, 32'd3,        32'd4,   OP_ADD,   32'h200,      32'd4,        32'd16,       5'd1,  6'b100010);
    vecs[9]  = mk(32'h00008067, 32'h300, 32'd3,        32'd4,   OP_ADD,   32'h300,      32'd4,        32'd0,        5'd0,  6'b000010);
    vecs[10] = mk(32'h00208033, 32'h120, 32'd5,        32'd7,   OP_ADD,   32'd5,        32'd7,        32'd0,        5'd0,  6'b000000);
    vecs[11] = mk(32'hFE209EE3, 32'h124, 32'd1,        32'd2,   OP_SUBNE, 32'd1,        32'd2,        32'hFFFFFFFC, 5'h1D, 6'b000100);
    vecs[12] = mk(32'hFFFFFFFF, 32'h128, 32'd3,        32'd4,   OP_ADD,   32'd0,        32'd0,        32'd0,        5'h1F, {5'b00000, EXP_ILL});
    curVec = vecs[0];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstValid", 32'(bus.outValid), 32'd0);
    checkOutput("rstReady", 32'(bus.inReady),  32'd1);
    checkOutput("rstAluOp", 32'(bus.aluOp),    32'(OP_ADD));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] back-to-back table");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(i, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    checkOutput("tableDrain", 32'(sb.size()), 32'd0);
    checkOutput("tableIdle",  32'(bus.outValid), 32'd0);

    $display("[TB] stall then release");
    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("stallReady", 32'(bus.inReady),  32'd0);
      checkOutput("stallValid", 32'(bus.outValid), 32'd1);
      checkOutput("stallAluA",  bus.aluA,          vecs[0].a);
      checkOutput("stallAluOp", 32'(bus.aluOp),    32'(OP_ADD));
    end
    applyStimulus(1, 1'b1, 1'b1, 1'b0);
    applyStimulus(2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("noBubbleValid", 32'(bus.outValid), 32'd1);
    checkOutput("noBubbleOp",    32'(bus.aluOp),    32'(OP_SUB));
    applyStimulus(2, 1'b0, 1'b1, 1'b0);
    applyStimulus(2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("stallDrain", 32'(bus.outValid), 32'd0);

    $display("[TB] flush");
    applyStimulus(3, 1'b1, 1'b1, 1'b0);
    applyStimulus(4, 1'b1, 1'b0, 1'b1);
    applyStimulus(4, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flushValid",  32'(bus.outValid), 32'd0);
    checkOutput("flushBranch", 32'(bus.isBranch), 32'd0);
    applyStimulus(5, 1'b1, 1'b1, 1'b1);
    applyStimulus(5, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flushEmpty", 32'(bus.outValid), 32'd0);

    $display("[TB] reset during stall");
    applyStimulus(6, 1'b1, 1'b1, 1'b0);
    applyStimulus(7, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    bus.inValid = 1'b0;
    @(negedge clk);
    checkOutput("midRstValid",  32'(bus.outValid), 32'd0);
    checkOutput("midRstAluA",   bus.aluA,          32'd0);
    checkOutput("midRstAluB",   bus.aluB,          32'd0);
    checkOutput("midRstAluOp",  32'(bus.aluOp),    32'(OP_ADD));
    checkOutput("midRstImm",    bus.imm,           32'd0);
    checkOutput("midRstPc",     bus.pcOut,         32'd0);
    checkOutput("midRstRd",     32'(bus.rd),       32'd0);
    checkOutput("midRstCtl",    32'({bus.rfWe, bus.memRe, bus.memWe,
                                     bus.isBranch, bus.isJump, bus.illegal}), 32'd0);

    @(negedge clk);
    checkOutput("finalQueue", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
